// File: rtl/lsu_bus_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_if
// Brief    : Valid/ready data bus with separate read-response channel.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_bus_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output valid, we, addr, wdata, be,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata, be,
    output ready, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_bus_adapter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_adapter
// Brief    : M-stage load/store unit driving a byte-lane valid/ready bus.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_bus_adapter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        MemReadM,
  input  wire logic        MemWriteM,
  input  wire logic [2:0]  Funct3M,
  input  wire logic [31:0] ALUResultM,
  input  wire logic [31:0] WriteDataM,
  output logic [31:0]      ReadDataM,
  output logic             StallM,
  output logic             FaultM,
  lsu_bus_if.master        bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] c_tcnt_last = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_valid;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [7:0]  r_tcnt;
  logic        r_tfault;
  logic [31:0] r_rdata;

  logic        w_req;
  logic        w_f3_ok;
  logic        w_align_ok;
  logic        w_legal;
  logic        w_idle_fault;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_ext;

  // Request decode and lane formatting for the access presented in IDLE.
  always_comb begin
    w_req      = MemReadM | MemWriteM;
    w_f3_ok    = 1'b0;
    w_align_ok = 1'b1;
    w_be       = 4'b1111;
    w_wdata    = WriteDataM;

    case (Funct3M)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = MemReadM;
      default:                w_f3_ok = 1'b0;
    endcase

    case (Funct3M[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALUResultM[1:0];
        w_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        w_align_ok = ~ALUResultM[0];
        w_be       = ALUResultM[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{WriteDataM[15:0]}};
      end
      default: begin
        w_align_ok = (ALUResultM[1:0] == 2'b00);
        w_be       = 4'b1111;
        w_wdata    = WriteDataM;
      end
    endcase

    if (!MemWriteM) begin
      w_wdata = 32'd0;
    end

    w_legal      = (MemReadM ^ MemWriteM) & w_f3_ok & w_align_ok;
    w_idle_fault = (r_state == ST_IDLE) & w_req & ~w_legal;
  end

  // Response lane select and extension, using the latched address/type.
  always_comb begin
    w_lane = bus.rdata >> {r_addr[1:0], 3'b000};
    case (r_funct3)
      3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ext = {24'd0, w_lane[7:0]};
      3'b101:  w_ext = {16'd0, w_lane[15:0]};
      default: w_ext = bus.rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_be     <= 4'd0;
      r_tcnt   <= 8'd0;
      r_tfault <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && w_legal) begin
            r_we     <= MemWriteM;
            r_funct3 <= Funct3M;
            r_addr   <= ALUResultM;
            r_wdata  <= w_wdata;
            r_be     <= w_be;
            r_tcnt   <= 8'd0;
            r_tfault <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.ready) begin
            r_valid <= 1'b0;
            r_tcnt  <= 8'd0;
            r_state <= r_we ? ST_DONE : ST_RESP;
          end else if (r_tcnt == c_tcnt_last) begin
            r_valid  <= 1'b0;
            r_tfault <= 1'b1;
            r_rdata  <= 32'd0;
            r_state  <= ST_DONE;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        ST_RESP: begin
          // A response arriving on the last allowed cycle still wins over the timeout.
          if (bus.rvalid) begin
            r_rdata <= w_ext;
            r_state <= ST_DONE;
          end else if (r_tcnt == c_tcnt_last) begin
            r_tfault <= 1'b1;
            r_rdata  <= 32'd0;
            r_state  <= ST_DONE;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        ST_DONE: begin
          r_tfault <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.valid = r_valid;
  assign bus.we    = r_we;
  assign bus.addr  = {r_addr[31:2], 2'b00};
  assign bus.wdata = r_wdata;
  assign bus.be    = r_be;

  assign StallM    = ~reset & (((r_state == ST_IDLE) & w_req & w_legal) |
                               (r_state == ST_REQ) | (r_state == ST_RESP));
  assign FaultM    = ~reset & (w_idle_fault | ((r_state == ST_DONE) & r_tfault));
  assign ReadDataM = w_idle_fault ? 32'd0 : r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_bus_adapter
// Brief    : Scoreboard bench: stimulus pushes expectations, monitor pops them.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lsu_bus_adapter;

  localparam int T = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  Funct3M = 3'd0;
  logic [31:0] ALUResultM = 32'd0;
  logic [31:0] WriteDataM = 32'd0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        FaultM;

  lsu_bus_if bus_if ();

  lsu_bus_adapter #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .FaultM     (FaultM),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct { logic fault; logic chk_rd; logic [31:0] rd; int stalls; } done_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } bus_t;

  done_t       done_q[$];
  bus_t        bus_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cur_d = 0;
  int          cur_r = 0;
  logic [31:0] cur_word = 32'd0;
  bit          force_rv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // ---------------- reference model ----------------
  function automatic int access_bytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit is_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                  input logic [31:0] a);
    bit f3ok;
    int n;
    if (rd == wr) return 1'b0;
    f3ok = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    n = access_bytes(f3);
    return f3ok && ((a % n) == 0);
  endfunction

  function automatic logic [3:0] lanes(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = access_bytes(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] store_data(input bit wr, input logic [2:0] f3,
                                             input logic [31:0] wd);
    int n;
    n = access_bytes(f3);
    if (!wr) return 32'd0;
    if (n == 1) return {24'd0, wd[7:0]} * 32'h01010101;
    if (n == 2) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    int n;
    logic [63:0] mask;
    logic [63:0] v;
    n = access_bytes(f3);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = ({32'd0, w} >> (8 * (a % 4))) & mask;
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---------------- stimulus ----------------
  // Called at the start of an IDLE cycle (posedge + #1); returns at the start of the next IDLE cycle.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int d, input int r, input logic [31:0] word);
    done_t e;
    bus_t  b;
    bit    done;
    cur_d = d; cur_r = r; cur_word = word;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
    if (!(rd || wr)) begin
      @(posedge clk); #1;
      return;
    end
    if (!is_legal(rd, wr, f3, a)) begin
      e = '{1'b1, 1'b1, 32'd0, 0};
      done_q.push_back(e);
      @(posedge clk); #1;
      return;
    end
    if (d < T) begin
      b = '{wr, a & 32'hFFFF_FFFC, store_data(wr, f3, wd), lanes(f3, a)};
      bus_q.push_back(b);
    end
    if (d >= T)      e = '{1'b1, 1'b1, 32'd0, 1 + T};
    else if (wr)     e = '{1'b0, 1'b0, 32'd0, d + 2};
    else if (r >= T) e = '{1'b1, 1'b1, 32'd0, d + 2 + T};
    else             e = '{1'b0, 1'b1, load_value(f3, a, word), d + r + 3};
    done_q.push_back(e);
    done = 1'b0;
    for (int n = 0; n < 3 * T; n++) begin
      @(posedge clk); #1;
      if (!StallM) begin done = 1'b1; break; end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL completion_wait actual=stalled required=done_within_%0d", 3 * T);
      finish_run();
    end
    // Inputs stay held through DONE so a re-issue would show up as an extra handshake.
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0]  legal_f3 [5];
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    int          kind;
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    repeat (2) @(negedge clk);
    chk("reset_valid", {31'd0, bus_if.valid}, 32'd0);
    chk("reset_stall", {31'd0, StallM}, 32'd0);
    chk("reset_fault", {31'd0, FaultM}, 32'd0);
    chk("reset_rdata", ReadDataM, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    do_access(0, 1, 3'b000, 32'h1003, 32'h0000_00A5, 0, 0, 32'd0);
    do_access(1, 0, 3'b001, 32'h2002, 32'd0, 0, 3, 32'h80FF_1234);
    do_access(1, 0, 3'b101, 32'h2002, 32'd0, 0, 3, 32'h80FF_1234);
    do_access(1, 0, 3'b010, 32'h3001, 32'd0, 0, 0, 32'd0);
    do_access(1, 0, 3'b010, 32'h4000, 32'd0, T, 0, 32'd0);
    do_access(1, 0, 3'b010, 32'h0000_0010, 32'd0, 0, 0, 32'h1111_2222);
    do_access(1, 0, 3'b010, 32'h0000_0014, 32'd0, 0, 0, 32'h3333_4444);

    // Reset while the load waits in RESP, then a stray response right after.
    cur_d = 0; cur_r = 50; cur_word = 32'h5555_AAAA;
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h40;
    bus_q.push_back('{1'b0, 32'h40, 32'd0, 4'hF});
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_reset_stall", {31'd0, StallM}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'd0, bus_if.valid}, 32'd0);
    chk("midrst_stall", {31'd0, StallM}, 32'd0);
    chk("midrst_fault", {31'd0, FaultM}, 32'd0);
    chk("midrst_rdata", ReadDataM, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0; force_rv = 1'b1; MemReadM = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("late_rv_valid", {31'd0, bus_if.valid}, 32'd0);
    chk("late_rv_stall", {31'd0, StallM}, 32'd0);
    chk("late_rv_fault", {31'd0, FaultM}, 32'd0);
    chk("late_rv_rdata", ReadDataM, 32'd0);
    @(posedge clk); #1;
    force_rv = 1'b0;
    @(posedge clk); #1;

    do_access(0, 1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, T - 1, 0, 32'd0);
    do_access(1, 0, 3'b000, 32'h0000_0031, 32'd0, 1, T, 32'h1234_5678);
    do_access(0, 1, 3'b001, 32'h0000_0040, 32'h0000_BEEF, T, 0, 32'd0);
    do_access(1, 0, 3'b100, 32'h0000_0051, 32'd0, 0, T - 1, 32'h00C3_0000);
    do_access(1, 1, 3'b000, 32'h0000_0060, 32'd0, 0, 0, 32'd0);
    do_access(0, 1, 3'b001, 32'h0000_0071, 32'h1234_5678, 0, 0, 32'd0);
    do_access(1, 0, 3'b110, 32'h0000_0080, 32'd0, 0, 0, 32'd0);
    do_access(0, 1, 3'b100, 32'h0000_0090, 32'h0000_00FF, 0, 0, 32'd0);

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      rd = (kind == 1) || (kind >= 2 && kind <= 5);
      wr = (kind == 1) || (kind >= 6);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      do_access(rd, wr, f3, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    MemReadM = 1'b0; MemWriteM = 1'b0;
    repeat (4) @(posedge clk);
    checks++;
    if (done_q.size() != 0 || bus_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=done%0d_bus%0d required=0_0", done_q.size(), bus_q.size());
    end
    finish_run();
  end

  // ---------------- bus slave ----------------
  initial begin
    int rk;
    int rj;
    bit in_resp;
    rk = 0; rj = 0; in_resp = 1'b0;
    bus_if.ready = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        in_resp = 1'b0; rk = 0;
        bus_if.ready = 1'b0; bus_if.rvalid = 1'b0;
      end else begin
        if (force_rv) begin
          bus_if.rvalid = 1'b1; bus_if.rdata = 32'hDEAD_BEEF;
        end else if (in_resp) begin
          if (rj >= cur_r) begin
            bus_if.rvalid = 1'b1; bus_if.rdata = cur_word; in_resp = 1'b0;
          end else begin
            bus_if.rvalid = 1'b0; bus_if.rdata = $urandom; rj++;
            if (rj > T) in_resp = 1'b0;
          end
        end else begin
          bus_if.rvalid = ($urandom_range(0, 3) == 0); bus_if.rdata = $urandom;
        end
        if (bus_if.valid) begin
          bus_if.ready = (rk >= cur_d);
          if (bus_if.ready) begin
            rk = 0;
            if (!bus_if.we) begin in_resp = 1'b1; rj = 0; end
          end else begin
            rk++;
          end
        end else begin
          bus_if.ready = ($urandom_range(0, 1) == 1); rk = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit    prev;
    int    scnt;
    done_t e;
    bus_t  b;
    prev = 1'b0; scnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0; scnt = 0;
        continue;
      end
      if (bus_if.valid && bus_if.ready) begin
        if (bus_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL bus_handshake actual=unexpected required=none addr=0x%08h", bus_if.addr);
        end else begin
          b = bus_q.pop_front();
          chk("bus_we", {31'd0, bus_if.we}, {31'd0, b.we});
          chk("bus_addr", bus_if.addr, b.addr);
          chk("bus_wdata", bus_if.wdata, b.wdata);
          chk("bus_be", {28'd0, bus_if.be}, {28'd0, b.be});
        end
      end
      if (StallM) scnt++;
      if ((prev && !StallM) || FaultM) begin
        if (done_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL completion actual=unexpected required=none fault=%0d", FaultM);
        end else begin
          e = done_q.pop_front();
          chk("fault", {31'd0, FaultM}, {31'd0, e.fault});
          if (e.chk_rd) chk("rdata", ReadDataM, e.rd);
          chk("stall_cycles", 32'(scnt), 32'(e.stalls));
        end
        scnt = 0;
      end
      prev = StallM;
    end
  end

endmodule
`default_nettype wire
